// File: rtl/branch_ctrl.sv
// Control-transfer resolver for the RV32I core: sequences the BranchComp comparator,
// decodes the branch condition, issues a redirect plus flush window, and counts branches.
module branch_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_is_branch,
    input  logic                  i_is_jal,
    input  logic                  i_is_jalr,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic [DATA_WIDTH-1:0] o_data2,
    output logic                  o_BranchOp,
    input  logic                  i_BrEq,
    input  logic                  i_BrLT,
    output logic                  o_redirect,
    output logic [DATA_WIDTH-1:0] o_target,
    output logic [DATA_WIDTH-1:0] o_link,
    output logic                  o_done,
    output logic                  o_taken,
    output logic                  o_illegal,
    output logic                  o_misalign,
    output logic                  o_flush,
    output logic [CNT_WIDTH-1:0]  o_branch_cnt,
    output logic [CNT_WIDTH-1:0]  o_taken_cnt
);

    localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StCmp, StResolve, StFlush} stateT;

    stateT                 stateQ, stateD;
    logic                  isBranchQ, isJalrQ;
    logic [2:0]            funct3Q;
    logic [DATA_WIDTH-1:0] pcQ, immQ, rs1Q, rs2Q;
    logic                  condQ;
    logic [DATA_WIDTH-1:0] targetQ, linkQ;
    logic [FlushW-1:0]     flushCntQ;
    logic [CNT_WIDTH-1:0]  branchCntQ, takenCntQ;

    logic                  oneType;
    logic                  accept;
    logic                  cmpCond;
    logic                  redirectNow;
    logic [DATA_WIDTH-1:0] jalrSum;

    always_comb begin
        oneType = 1'b0;
        case ({i_is_branch, i_is_jal, i_is_jalr})
            3'b100, 3'b010, 3'b001: oneType = 1'b1;
            default:                oneType = 1'b0;
        endcase
    end

    // Requests with zero or several type bits are still handshaken, then discarded.
    assign accept = (stateQ == StIdle) && i_valid && oneType;

    always_comb begin
        cmpCond = 1'b1;
        if (isBranchQ) begin
            case (funct3Q)
                3'b000:         cmpCond = i_BrEq;
                3'b001:         cmpCond = !i_BrEq;
                3'b100, 3'b110: cmpCond = i_BrLT;
                3'b101, 3'b111: cmpCond = !i_BrLT;
                default:        cmpCond = 1'b0;
            endcase
        end
    end

    assign jalrSum     = rs1Q + immQ;
    assign redirectNow = (stateQ == StResolve) && condQ && !targetQ[1];

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:    if (accept) stateD = StCmp;
            StCmp:     stateD = StResolve;
            StResolve: stateD = redirectNow ? StFlush : StIdle;
            StFlush:   if (flushCntQ == '0) stateD = StIdle;
            default:   stateD = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stateQ     <= StIdle;
            isBranchQ  <= 1'b0;
            isJalrQ    <= 1'b0;
            funct3Q    <= '0;
            pcQ        <= '0;
            immQ       <= '0;
            rs1Q       <= '0;
            rs2Q       <= '0;
            condQ      <= 1'b0;
            targetQ    <= '0;
            linkQ      <= '0;
            flushCntQ  <= '0;
            branchCntQ <= '0;
            takenCntQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (accept) begin
                isBranchQ <= i_is_branch;
                isJalrQ   <= i_is_jalr;
                funct3Q   <= i_funct3;
                pcQ       <= i_pc;
                immQ      <= i_imm;
                rs1Q      <= i_rs1_data;
                rs2Q      <= i_rs2_data;
            end
            if (stateQ == StCmp) begin
                condQ   <= cmpCond;
                targetQ <= isJalrQ ? {jalrSum[DATA_WIDTH-1:1], 1'b0} : pcQ + immQ;
                linkQ   <= pcQ + DATA_WIDTH'(4);
            end
            if (stateQ == StResolve) begin
                flushCntQ <= FlushW'(FLUSH_CYCLES - 1);
                if (isBranchQ) begin
                    branchCntQ <= branchCntQ + 1'b1;
                    if (redirectNow) takenCntQ <= takenCntQ + 1'b1;
                end
            end else if (stateQ == StFlush) begin
                flushCntQ <= flushCntQ - 1'b1;
            end
        end
    end

    assign o_ready      = (stateQ == StIdle);
    assign o_data1      = rs1Q;
    assign o_data2      = rs2Q;
    assign o_BranchOp   = (stateQ == StCmp) && (funct3Q[2:1] == 2'b11);
    assign o_done       = (stateQ == StResolve);
    assign o_redirect   = redirectNow;
    assign o_taken      = redirectNow;
    assign o_misalign   = (stateQ == StResolve) && condQ && targetQ[1];
    assign o_illegal    = (stateQ == StResolve) && isBranchQ && (funct3Q[2:1] == 2'b01);
    assign o_flush      = redirectNow || (stateQ == StFlush);
    assign o_target     = targetQ;
    assign o_link       = linkQ;
    assign o_branch_cnt = branchCntQ;
    assign o_taken_cnt  = takenCntQ;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a stimulus process pushes model results, a monitor
// process pops and compares them whenever the controller reports a resolution.
module tb_branch_ctrl;

    localparam int DW = 32;
    localparam int FC = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic          isBranch, isJal, isJalr;
    logic [2:0]    funct3;
    logic [DW-1:0] pc, imm, rs1, rs2;
    logic [DW-1:0] data1, data2;
    logic          branchOp;
    logic          brEq, brLT;
    logic          redirect;
    logic [DW-1:0] target, link;
    logic          done, taken, illegal, misalign, flush;
    logic [CW-1:0] branchCnt, takenCnt;

    branch_ctrl #(
        .DATA_WIDTH  (DW),
        .FLUSH_CYCLES(FC),
        .CNT_WIDTH   (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_is_branch (isBranch),
        .i_is_jal    (isJal),
        .i_is_jalr   (isJalr),
        .i_funct3    (funct3),
        .i_pc        (pc),
        .i_imm       (imm),
        .i_rs1_data  (rs1),
        .i_rs2_data  (rs2),
        .o_data1     (data1),
        .o_data2     (data2),
        .o_BranchOp  (branchOp),
        .i_BrEq      (brEq),
        .i_BrLT      (brLT),
        .o_redirect  (redirect),
        .o_target    (target),
        .o_link      (link),
        .o_done      (done),
        .o_taken     (taken),
        .o_illegal   (illegal),
        .o_misalign  (misalign),
        .o_flush     (flush),
        .o_branch_cnt(branchCnt),
        .o_taken_cnt (takenCnt)
    );

    // BranchComp stand-in.
    assign brEq = (data1 == data2);
    assign brLT = branchOp ? (data1 < data2) : ($signed(data1) < $signed(data2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          branchOp;
        logic [DW-1:0] d1, d2, target, link;
        logic          taken, illegal, misalign, isBranch;
        int            cyc;
    } expT;

    expT           expQ[$];
    int            nCmp = 0;
    int            nBad = 0;
    logic [CW-1:0] mBranchCnt = '0;
    logic [CW-1:0] mTakenCnt = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: resolve the instruction straight from the ISA rules.
    function automatic expT model(input logic b, input logic jr, input logic [2:0] f3,
                                  input logic [DW-1:0] p, input logic [DW-1:0] i,
                                  input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        expT e;
        logic cond;
        logic [DW-1:0] sum;
        e.branchOp = (f3 == 3'd6) || (f3 == 3'd7);
        e.d1 = r1;
        e.d2 = r2;
        e.isBranch = b;
        e.illegal = b && (f3 == 3'd2 || f3 == 3'd3);
        cond = 1'b1;
        if (b) begin
            case (f3)
                3'd0: cond = (r1 == r2);
                3'd1: cond = (r1 != r2);
                3'd4: cond = ($signed(r1) < $signed(r2));
                3'd5: cond = ($signed(r1) >= $signed(r2));
                3'd6: cond = (r1 < r2);
                3'd7: cond = (r1 >= r2);
                default: cond = 1'b0;
            endcase
        end
        if (jr) begin
            sum = r1 + i;
            e.target = sum & ~32'd1;
        end else begin
            e.target = p + i;
        end
        e.link = p + 32'd4;
        e.taken = cond && !e.target[1];
        e.misalign = cond && e.target[1];
        e.cyc = 0;
        return e;
    endfunction

    task automatic issue(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                         input logic [DW-1:0] p, input logic [DW-1:0] i,
                         input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        expT e;
        bit  ok = 0;
        isBranch = b; isJal = j; isJalr = jr; funct3 = f3;
        pc = p; imm = i; rs1 = r1; rs2 = r2;
        valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1;
                if (int'(b) + int'(j) + int'(jr) == 1) begin
                    e = model(b, jr, f3, p, i, r1, r2);
                    e.cyc = cyc;
                    expQ.push_back(e);
                end
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // Monitor.
    int flushLeft = 0;
    bit readyPend = 0;
    bit cntPend = 0;
    always @(negedge clk) begin
        expT e;
        if (!rst) begin
            if (cntPend) begin
                check("branch_cnt", DW'(branchCnt), DW'(mBranchCnt));
                check("taken_cnt", DW'(takenCnt), DW'(mTakenCnt));
                cntPend = 0;
            end
            if (done) begin
                if (expQ.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("latency", cyc, e.cyc + 2);
                    check("taken", DW'(taken), DW'(e.taken));
                    check("redirect", DW'(redirect), DW'(e.taken));
                    check("illegal", DW'(illegal), DW'(e.illegal));
                    check("misalign", DW'(misalign), DW'(e.misalign));
                    check("flush_resolve", DW'(flush), DW'(e.taken));
                    check("ready_resolve", DW'(ready), 32'd0);
                    check("target", target, e.target);
                    check("link", link, e.link);
                    if (e.isBranch) mBranchCnt = mBranchCnt + 1'b1;
                    if (e.isBranch && e.taken) mTakenCnt = mTakenCnt + 1'b1;
                    cntPend = 1;
                    flushLeft = e.taken ? FC : 0;
                    readyPend = 1;
                end
            end else begin
                check("redirect_idle", DW'(redirect), 32'd0);
                if (flushLeft > 0) begin
                    check("flush_hold", DW'(flush), 32'd1);
                    check("ready_flush", DW'(ready), 32'd0);
                    flushLeft--;
                end else if (readyPend) begin
                    check("ready_after", DW'(ready), 32'd1);
                    check("flush_after", DW'(flush), 32'd0);
                    readyPend = 0;
                end else if (!ready && !flush && expQ.size() > 0) begin
                    check("branch_op", DW'(branchOp), DW'(expQ[0].branchOp));
                    check("data1", data1, expQ[0].d1);
                    check("data2", data2, expQ[0].d2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ty;
        logic [DW-1:0] r1, r2, p, i;
        rst = 1'b1; valid = 1'b0; isBranch = 0; isJal = 0; isJalr = 0; funct3 = '0;
        pc = '0; imm = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", DW'(ready), 32'd1);
        check("rst_done", DW'(done), 32'd0);
        check("rst_flush", DW'(flush), 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_link", link, 32'd0);
        check("rst_data1", data1, 32'd0);
        check("rst_bop", DW'(branchOp), 32'd0);
        check("rst_bcnt", DW'(branchCnt), 32'd0);
        check("rst_tcnt", DW'(takenCnt), 32'd0);
        @(posedge clk); #1;

        // Directed cases.
        issue(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0200_0000, 32'h0200_0000);
        issue(1, 0, 0, 3'b100, 32'h200, 32'h40, 32'h8200_0000, 32'h1);
        issue(1, 0, 0, 3'b110, 32'h200, 32'h40, 32'h8200_0000, 32'h1);
        issue(0, 0, 1, 3'b000, 32'h300, 32'h0, 32'h1003, 32'h0);
        issue(0, 0, 1, 3'b000, 32'h300, 32'h0, 32'h1001, 32'h0);
        issue(1, 0, 0, 3'b010, 32'h500, 32'h8, 32'h5, 32'h5);
        issue(0, 1, 0, 3'b011, 32'h400, 32'h10, 32'h0, 32'h0);
        issue(0, 0, 0, 3'b000, 32'h600, 32'h10, 32'h0, 32'h0);
        issue(1, 1, 0, 3'b000, 32'h600, 32'h10, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1;

        // Reset while the comparator is being sequenced.
        issue(1, 0, 0, 3'b000, 32'h700, 32'h20, 32'h9, 32'h9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        mBranchCnt = '0;
        mTakenCnt = '0;
        @(negedge clk);
        check("abort_ready", DW'(ready), 32'd1);
        check("abort_done", DW'(done), 32'd0);
        check("abort_redirect", DW'(redirect), 32'd0);
        check("abort_bcnt", DW'(branchCnt), 32'd0);
        check("abort_tcnt", DW'(takenCnt), 32'd0);
        @(posedge clk); #1;

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            r1 = $urandom;
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            if ($urandom_range(0, 3) == 0) r2 = {r1[31], 31'($urandom)};
            p = $urandom & 32'hFFFF_FFFC;
            i = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            case ($urandom_range(0, 7))
                0, 1, 2, 5: ty = 3'b100;
                3:          ty = 3'b010;
                4:          ty = 3'b001;
                6:          ty = 3'b000;
                default:    ty = 3'($urandom);
            endcase
            issue(ty[2], ty[1], ty[0], 3'($urandom), p, i, r1, r2);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end

        // Back-to-back taken branches with valid held high; long enough to wrap counters.
        for (int n = 0; n < 260; n++) begin
            r1 = $urandom;
            issue(1, 0, 0, 3'b000, 32'h1000, 32'h80, r1, r1);
        end

        repeat (12) @(posedge clk);
        @(negedge clk);
        check("queue_drained", expQ.size(), 32'd0);
        check("final_tcnt", DW'(takenCnt), DW'(mTakenCnt));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequences the BranchComp comparator for the RV32I core and resolves control-transfer instructions (B-type, JAL, JALR). It accepts one request at a time over a valid/ready handshake, drives the comparator operands and signedness select, evaluates funct3, computes the target, and issues a one-cycle redirect followed by a pipeline flush window. It sits between decode/operand fetch and the PC/fetch logic, and it also keeps simple branch statistics counters.

Parameters:
DATA_WIDTH, 32, width of operands, PC and immediate
FLUSH_CYCLES, 2, cycles o_flush is held after a taken redirect (≥1)
CNT_WIDTH, 16, width of statistics counters

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  request valid
o_ready  output  1  controller can accept a request
i_is_branch  input  1  B-type instruction
i_is_jal  input  1  JAL
i_is_jalr  input  1  JALR
i_funct3  input  3  branch condition
i_pc  input  DATA_WIDTH  instruction PC
i_imm  input  DATA_WIDTH  sign-extended immediate
i_rs1_data  input  DATA_WIDTH  rs1 value
i_rs2_data  input  DATA_WIDTH  rs2 value
o_data1  output  DATA_WIDTH  comparator operand 1
o_data2  output  DATA_WIDTH  comparator operand 2
o_BranchOp  output  1  comparator select: 1 = unsigned, 0 = signed
i_BrEq  input  1  comparator equal result
i_BrLT  input  1  comparator less-than result
o_redirect  output  1  one-cycle pulse: load o_target into the PC
o_target  output  DATA_WIDTH  redirect target, held until the next resolve
o_link  output  DATA_WIDTH  pc+4 for JAL/JALR writeback, valid with o_done
o_done  output  1  one-cycle pulse: resolution complete
o_taken  output  1  valid with o_done: transfer taken
o_illegal  output  1  valid with o_done: funct3 010/011 on a branch
o_misalign  output  1  valid with o_done: taken target bit[1] set
o_flush  output  1  squash younger instructions
o_branch_cnt  output  CNT_WIDTH  resolved B-type count
o_taken_cnt  output  CNT_WIDTH  taken B-type count

Behaviour:
- Reset: state IDLE; o_ready=1; all pulses, o_flush, o_taken, o_illegal, o_misalign = 0; o_data1, o_data2, o_target, o_link = 0; o_BranchOp=0; counters = 0. Reset mid-operation aborts to IDLE with no redirect.
- FSM states: IDLE, CMP, RESOLVE, FLUSH.
- IDLE: o_ready=1. If i_valid=1 and exactly one of is_branch/is_jal/is_jalr is set, register the request and go to CMP. If i_valid=1 with zero or multiple type bits, the request is accepted and dropped; there is no done pulse.
- CMP: o_ready=0. o_data1/o_data2 are driven from the registered rs1/rs2. o_BranchOp=1 iff funct3 ∈ {110,111}. i_BrEq/i_BrLT are sampled at the end of the cycle. Target computation: branch/JAL = pc+imm; JALR = (rs1+imm) with bit0 cleared. Addition wraps modulo 2^DATA_WIDTH. Link = pc+4.
- Condition decode: 000 BEQ = BrEq; 001 BNE = !BrEq; 100 BLT / 110 BLTU = BrLT; 101 BGE / 111 BGEU = !BrLT; 010/011 = illegal, not taken. JAL/JALR are always taken.
- RESOLVE (exactly one cycle): o_done=1.
  - If taken and target[1]=0: o_redirect=1, o_taken=1, then go to FLUSH.
  - If taken with target[1]=1: o_misalign=1, o_taken=0, no redirect, go to IDLE.
  - If not taken: go to IDLE.
  - o_flush=1 is also asserted in this cycle when redirecting.
  - Counters update here: o_branch_cnt+1 for any B-type, including illegal; o_taken_cnt+1 for a B-type redirect. Both wrap at 2^CNT_WIDTH.
- FLUSH: o_flush=1 for FLUSH_CYCLES cycles, o_ready=0, then go to IDLE. The total o_flush high time is FLUSH_CYCLES+1, counting the RESOLVE cycle.
- Latency: handshake at cycle 0, CMP at cycle 1, o_done/o_redirect at cycle 2. Earliest next accept: cycle 3 if not taken, cycle 3+FLUSH_CYCLES if taken.
- Outputs o_target and o_link hold their values until the next RESOLVE.

Test Plan:
- BEQ, rs1=rs2=0x02000000, pc=0x100, imm=0x20 -> cycle 2: o_redirect=1, o_target=0x120; o_flush high 3 cycles; o_taken_cnt=1.
- BLT vs BLTU, rs1=0x82000000, rs2=0x00000001 -> BLT: o_BranchOp=0, taken; BLTU: o_BranchOp=1, not taken, no redirect, o_ready back at cycle 3.
- JALR, rs1=0x1003, imm=0 -> o_target=0x1002, o_misalign=1, no redirect. JALR, rs1=0x1001 -> target 0x1000, redirect, o_link=pc+4.
- Branch funct3=010 -> o_illegal=1, not taken, o_branch_cnt increments.
- i_rst asserted during CMP -> next cycle IDLE, o_ready=1, no o_done or o_redirect; counters = 0.
- Back-to-back i_valid held high with taken branches -> accepts spaced 3+FLUSH_CYCLES cycles apart; o_taken_cnt wraps 0xFFFF to 0x0000.
